// File: rtl/qpp_block_interleaver.sv
// Bit-serial QPP turbo-code block interleaver: buffers one block, then emits out[j] = in[(F1*j + F2*j*j) mod K].
// Define QPP_PINGPONG_EN for two storage banks so filling block n+1 overlaps draining block n.
module qpp_block_interleaver #(
  parameter int unsigned K_SMALL  = 1056,
  parameter int unsigned F1_SMALL = 17,
  parameter int unsigned F2_SMALL = 66,
  parameter int unsigned K_LARGE  = 6144,
  parameter int unsigned F1_LARGE = 263,
  parameter int unsigned F2_LARGE = 480,
  parameter int unsigned AW       = 13
) (
  input  logic clk,
  input  logic clear_n,
  input  logic k_size,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_first,
  output logic out_last
);

`ifdef QPP_PINGPONG_EN
  localparam int unsigned NBANK = 2;
  localparam logic        PP    = 1'b1;
`else
  localparam int unsigned NBANK = 1;
  localparam logic        PP    = 1'b0;
`endif
  localparam int unsigned MEM_D = NBANK * K_LARGE;
  localparam int unsigned MAW   = $clog2(MEM_D);

  localparam logic [AW:0]   KS   = (AW+1)'(K_SMALL);
  localparam logic [AW:0]   KL   = (AW+1)'(K_LARGE);
  localparam logic [AW-1:0] G0_S = AW'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [AW-1:0] G0_L = AW'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [AW-1:0] D_S  = AW'((2 * F2_SMALL) % K_SMALL);
  localparam logic [AW-1:0] D_L  = AW'((2 * F2_LARGE) % K_LARGE);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_RUN}  rstate_t;

  wstate_t       wstate_q, wstate_d;
  rstate_t       rstate_q, rstate_d;
  logic          wb_q, wb_d, rb_q, rb_d, rtag_q, rtag_d;
  logic [1:0]    full_q, full_d, tag_q, tag_d;
  logic [AW-1:0] wcnt_q, wcnt_d, j_q, j_d, pi_q, pi_d, g_q, g_d;
  logic          rdy_q, rdy_d, ov_q, ov_d, ob_q, ob_d, of_q, of_d, ol_q, ol_d;
  logic          we_c, start_c, sbank_c, rlast_c, nb_c;
  logic [MAW-1:0] waddr_c;
  logic [AW:0]   rk_c;
  logic [AW-1:0] rd2_c;
  logic          mem_q [0:MEM_D-1];

  // Sum of two residues below k, reduced with one conditional subtract.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW:0] k);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= k) s = s - k;
    return s[AW-1:0];
  endfunction

  function automatic logic [MAW-1:0] bank_addr(input logic bank, input logic [AW-1:0] a);
    return MAW'(a) + (bank ? MAW'(K_LARGE) : MAW'(0));
  endfunction

  function automatic logic [AW-1:0] last_idx(input logic lg);
    return lg ? AW'(K_LARGE - 1) : AW'(K_SMALL - 1);
  endfunction

  always_comb begin
    wstate_d = wstate_q;
    wb_d     = wb_q;
    wcnt_d   = wcnt_q;
    full_d   = full_q;
    tag_d    = tag_q;
    rstate_d = rstate_q;
    rb_d     = rb_q;
    rtag_d   = rtag_q;
    j_d      = j_q;
    pi_d     = pi_q;
    g_d      = g_q;
    ov_d     = ov_q;
    ob_d     = ob_q;
    of_d     = of_q;
    ol_d     = ol_q;
    we_c     = 1'b0;
    waddr_c  = bank_addr(wb_q, wcnt_q);
    start_c  = 1'b0;
    sbank_c  = rb_q;
    rlast_c  = (j_q == last_idx(rtag_q));
    nb_c     = rb_q ^ PP;
    rk_c     = rtag_q ? KL : KS;
    rd2_c    = rtag_q ? D_L : D_S;

    // Writer: the first bit of a block fixes the block size for that bank.
    if (in_valid && rdy_q) begin
      we_c = 1'b1;
      if (wstate_q == W_IDLE) begin
        tag_d[wb_q] = k_size;
        wstate_d    = W_FILL;
        wcnt_d      = AW'(1);
      end else if (wcnt_q == last_idx(tag_q[wb_q])) begin
        full_d[wb_q] = 1'b1;
        wstate_d     = W_IDLE;
        wcnt_d       = '0;
        wb_d         = wb_q ^ PP;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end

    if (out_ready) begin
      ov_d = 1'b0;
      of_d = 1'b0;
      ol_d = 1'b0;
    end

    // Reader: issue one permuted bit whenever the output register is free.
    if (rstate_q == R_IDLE) begin
      start_c = full_q[rb_q];
    end else if (!ov_q || out_ready) begin
      ov_d = 1'b1;
      ob_d = mem_q[bank_addr(rb_q, pi_q)];
      of_d = (j_q == '0);
      ol_d = rlast_c;
      if (rlast_c) begin
        full_d[rb_q] = 1'b0;
        rb_d         = nb_c;
        rstate_d     = R_IDLE;
        start_c      = PP && full_q[nb_c];
        sbank_c      = nb_c;
      end else begin
        pi_d = mod_add(pi_q, g_q, rk_c);
        g_d  = mod_add(g_q, rd2_c, rk_c);
        j_d  = j_q + AW'(1);
      end
    end

    if (start_c) begin
      rstate_d = R_RUN;
      rtag_d   = tag_q[sbank_c];
      j_d      = '0;
      pi_d     = '0;
      g_d      = tag_q[sbank_c] ? G0_L : G0_S;
    end

    // With one bank the next block waits until the last output bit has been taken.
    rdy_d = !full_d[wb_d] && !(!PP && ov_d && ol_d);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      rtag_q   <= 1'b0;
      full_q   <= '0;
      tag_q    <= '0;
      wcnt_q   <= '0;
      j_q      <= '0;
      pi_q     <= '0;
      g_q      <= '0;
      rdy_q    <= 1'b0;
      ov_q     <= 1'b0;
      ob_q     <= 1'b0;
      of_q     <= 1'b0;
      ol_q     <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      rtag_q   <= rtag_d;
      full_q   <= full_d;
      tag_q    <= tag_d;
      wcnt_q   <= wcnt_d;
      j_q      <= j_d;
      pi_q     <= pi_d;
      g_q      <= g_d;
      rdy_q    <= rdy_d;
      ov_q     <= ov_d;
      ob_q     <= ob_d;
      of_q     <= of_d;
      ol_q     <= ol_d;
    end
  end

  // Block storage carries no reset; full flags alone qualify its contents.
  always_ff @(posedge clk) begin
    if (we_c) mem_q[waddr_c] <= in_bit;
  end

  assign in_ready  = rdy_q;
  assign out_valid = ov_q;
  assign out_bit   = ob_q;
  assign out_first = of_q;
  assign out_last  = ol_q;

endmodule

// File: tb/tb_qpp_block_interleaver.sv
// Self-checking bench for qpp_block_interleaver: expected streams are built from the QPP formula directly.
module tb_qpp_block_interleaver;
  localparam int KS = 1056, F1S = 17,  F2S = 66;
  localparam int KL = 6144, F1L = 263, F2L = 480;

  logic clk = 1'b0, clear_n = 1'b0, k_size = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_bit, out_first, out_last;

  typedef struct packed {logic b; logic f; logic l; logic arm; logic disarm;} exp_t;

  int checks = 0, failures = 0, cyc = 0, inflight = 0, last_acc = 0, oj = 0, mark_j = -1, gaps = 0;
  int unsigned rdy_pct = 100, vld_pct = 100;
  bit rdy_chk = 0, lat_want = 0, lat_arm = 0, gap_arm = 0, stall_prev = 0;
  logic sb, sf, sl;
  bit send_q[$], ks_q[$], lastf_q[$];
  exp_t exp_q[$];

  qpp_block_interleaver #(
    .K_SMALL(KS), .F1_SMALL(F1S), .F2_SMALL(F2S),
    .K_LARGE(KL), .F1_LARGE(F1L), .F2_LARGE(F2L), .AW(13)
  ) dut (
    .clk(clk), .clear_n(clear_n), .k_size(k_size), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one block for input and append its permuted image to the expected stream.
  task automatic add_block(input bit lg, input int marker, input bit toggle, input bit arm, input bit disarm);
    int k;
    longint f1, f2, jj, p;
    bit d[KL];
    exp_t e;
    k  = lg ? KL : KS;
    f1 = lg ? F1L : F1S;
    f2 = lg ? F2L : F2S;
    for (int i = 0; i < k; i++) begin
      d[i] = (marker >= 0) ? (i == marker) : 1'($urandom);
      send_q.push_back(d[i]);
      ks_q.push_back((toggle && i > k / 2) ? !lg : lg);
      lastf_q.push_back(i == k - 1);
    end
    for (int j = 0; j < k; j++) begin
      jj = j;
      p  = (f1 * jj + f2 * jj * jj) % longint'(k);
      e.b = d[int'(p)];
      e.f = (j == 0);
      e.l = (j == k - 1);
      e.arm = arm && (j == 0);
      e.disarm = disarm && (j == k - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: check current outputs, then drive inputs for the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      chk("hold_bit", 32'(out_bit), 32'(sb));
      chk("hold_first", 32'(out_first), 32'(sf));
      chk("hold_last", 32'(out_last), 32'(sl));
    end
    if (rdy_chk) begin
`ifdef QPP_PINGPONG_EN
      if (inflight <= 1) chk("in_ready", 32'(in_ready), 32'(1));
`else
      chk("in_ready", 32'(in_ready), 32'(inflight == 0));
`endif
    end
    if (lat_arm && out_valid === 1'b1) begin
      chk("latency", 32'(cyc - last_acc), 32'(3));
      lat_arm = 0;
    end
    if (gap_arm && out_valid !== 1'b1) gaps++;

    out_ready = ($urandom_range(99) < rdy_pct);
    if (send_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      in_valid = 1'b1;
      in_bit   = send_q[0];
      k_size   = ks_q[0];
    end else begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      k_size   = 1'($urandom);
    end
    if (in_valid && in_ready === 1'b1) begin
      if (lastf_q[0]) begin
        inflight++;
        last_acc = cyc;
        if (lat_want) begin lat_arm = 1; lat_want = 0; end
      end
      void'(send_q.pop_front());
      void'(ks_q.pop_front());
      void'(lastf_q.pop_front());
    end
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(exp_q.size()), 32'(1));
      end else begin
        e = exp_q.pop_front();
        chk("out_bit", 32'(out_bit), 32'(e.b));
        chk("out_first", 32'(out_first), 32'(e.f));
        chk("out_last", 32'(out_last), 32'(e.l));
        oj = e.f ? 0 : oj + 1;
        if (out_bit === 1'b1) mark_j = oj;
        if (e.arm) gap_arm = 1;
        if (e.disarm) gap_arm = 0;
        if (e.l) inflight--;
      end
    end
    stall_prev = (out_valid === 1'b1) && !out_ready;
    sb = out_bit;
    sf = out_first;
    sl = out_last;
  endtask

  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    chk("drained", 32'(send_q.size() + exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_bit", 32'(out_bit), 32'(0));
    chk("rst_out_first", 32'(out_first), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    send_q.delete();
    ks_q.delete();
    lastf_q.delete();
    exp_q.delete();
    inflight = 0;
    stall_prev = 0;
    lat_arm = 0;
    lat_want = 0;
    gap_arm = 0;
    rdy_chk = 0;
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(in_ready), 32'(1));
    rdy_chk = 1;
  endtask

  initial begin
    do_reset();

    // Small block, marker at pi(1) = 83, with first-output latency.
    mark_j = -1;
    lat_want = 1;
    add_block(1'b0, 83, 1'b0, 1'b0, 1'b0);
    run_until_idle(5000);
    chk("mark_small_j1", 32'(mark_j), 32'(1));

    // Markers at pi(2), pi(3), pi(4) of the small block.
    mark_j = -1;
    add_block(1'b0, 298, 1'b0, 1'b0, 1'b0);
    run_until_idle(5000);
    chk("mark_small_j2", 32'(mark_j), 32'(2));
    mark_j = -1;
    add_block(1'b0, 645, 1'b0, 1'b0, 1'b0);
    run_until_idle(5000);
    chk("mark_small_j3", 32'(mark_j), 32'(3));
    mark_j = -1;
    add_block(1'b0, 68, 1'b0, 1'b0, 1'b0);
    run_until_idle(5000);
    chk("mark_small_j4", 32'(mark_j), 32'(4));

    // Large block, marker at pi(1) = 743.
    mark_j = -1;
    add_block(1'b1, 743, 1'b0, 1'b0, 1'b0);
    run_until_idle(20000);
    chk("mark_large_j1", 32'(mark_j), 32'(1));

    // Back-to-back blocks of both sizes with k_size toggled mid-block.
    gaps = 0;
    add_block(1'b0, -1, 1'b1, 1'b0, 1'b0);
    add_block(1'b1, -1, 1'b1, 1'b1, 1'b0);
    add_block(1'b0, -1, 1'b1, 1'b0, 1'b1);
    run_until_idle(30000);
`ifdef QPP_PINGPONG_EN
    chk("out_valid_gaps", 32'(gaps), 32'(0));
`endif

    // Random input gaps and 50% output backpressure.
    rdy_pct = 50;
    vld_pct = 80;
    add_block(1'b0, -1, 1'b0, 1'b0, 1'b0);
    add_block(1'b0, -1, 1'b1, 1'b0, 1'b0);
    run_until_idle(20000);

    // Reset mid-fill, then mid-drain, then one clean block.
    rdy_pct = 100;
    vld_pct = 100;
    add_block(1'b1, -1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) step();
    do_reset();
    add_block(1'b0, -1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 1356; n++) step();
    do_reset();
    add_block(1'b0, -1, 1'b0, 1'b0, 1'b0);
    run_until_idle(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qpp_block_interleaver.md
# qpp_block_interleaver

- Parametrised bit-serial turbo-code block interleaver with two selectable block sizes.
- Accepts an input bit stream over a valid/ready handshake and buffers one whole block.
- Emits the block bit-serially in quadratic-permutation-polynomial (QPP) order: out[j] = in[π(j)], with π(j) = (F1·j + F2·j²) mod K.
- Sits between the coder's serial data path and the rate-matching stage. It replaces the fixed shift-register-plus-combinational-permuter arrangement with address-generated reads.

## Interface
Parameters:
- K_SMALL, 1056: small block size in bits.
- F1_SMALL, 17: QPP f1 coefficient for the small block.
- F2_SMALL, 66: QPP f2 coefficient for the small block.
- K_LARGE, 6144: large block size in bits; sets storage depth per bank.
- F1_LARGE, 263: QPP f1 coefficient for the large block.
- F2_LARGE, 480: QPP f2 coefficient for the large block.
- AW, 13: address width; must satisfy 2^AW ≥ K_LARGE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- k_size  in  1  block-size select: 0 = K_SMALL, 1 = K_LARGE. Sampled with the first bit of each block.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  block can accept a bit this cycle.
- in_bit  in  1  serial data bit.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  downstream accepts out_bit this cycle.
- out_bit  out  1  permuted serial data bit.
- out_first  out  1  out_bit is bit j = 0 of a block.
- out_last  out  1  out_bit is bit j = K−1 of a block.

## Operation
- **Reset values.** Asserting clear_n low asynchronously clears all bank full flags, the write counter, the read counter, and π/g. It also drives in_ready=0, out_valid=0, out_bit=0, out_first=0, out_last=0. Any partial or pending block is discarded.
- **After reset.** in_ready rises on the first clk edge after clear_n is released.
- **Writer states.** W_IDLE → W_FILL on the first accepted bit. In that cycle k_size is latched as the bank tag and the bit is written to address 0.
- **Writer fill.** In W_FILL, each accepted bit (in_valid && in_ready) is written at address wcnt, then wcnt increments.
- **End of block.** The bit accepted at wcnt = K−1 sets the bank full flag. The writer then returns to W_IDLE and toggles to the other bank.
- **Block-size changes.** A change on k_size during W_FILL is ignored until the next block.
- **in_ready.** in_ready = 1 when the writer's current bank is not full.
- **Reader states.** R_IDLE → R_RUN when the reader's bank is full. On entry it loads j=0, π=0, and g=(F1+F2) mod K, using the bank's tag to select K/F1/F2.
- **Reader address recursion.** Each bit issued in R_RUN reads mem[π]. The counters then advance:
  - π ← (π+g) mod K
  - g ← (g + (2·F2 mod K)) mod K
  - j ← j+1
- **Modular adds.** Both operands are < K, so each mod-K add is one add plus one conditional subtract. No multipliers are used.
- **Output register.** The output register loads when it is empty or being consumed (!out_valid || out_ready). It holds its value while out_valid && !out_ready.
- **Output flags.** out_first is high with j=0 and out_last is high with j=K−1.
- **Releasing a bank.** Issuing j=K−1 clears the bank full flag and toggles the reader bank. The reader then goes to R_IDLE, or re-enters R_RUN next cycle if the other bank is already full.
- **Simultaneous events.** Writer-set and reader-clear of full flags on different banks in the same cycle both take effect. With two banks, the writer and reader never target the same bank in R_RUN.

## Timing
- **Input throughput.** One bit per cycle while in_ready stays high.
- **Block latency.** The last input bit of a block is accepted at edge E. The reader enters R_RUN at edge E+1, and the first out_valid is high after edge E+2.
- **Output throughput.** One bit per cycle with out_ready held high. out_valid stays high continuously across back-to-back blocks.
- **Backpressure.** When out_ready is low, out_bit, out_first, out_last and the read pointers all hold.

## Configuration
- **Macro:** QPP_PINGPONG_EN.
- **Defined:** two storage banks of K_LARGE bits each. Filling block n+1 overlaps draining block n.
- **Undefined:** one bank only.
  - in_ready is low from the edge accepting bit K−1 until the edge after the out_last handshake.
  - Input of the next block does not start before then.
  - All other behaviour is identical.

## Test plan
1. **Small block, single marker.** k_size=0; input bit i = (i==83), 1056 bits, out_ready=1 → out_bit=1 only at j=1. out_first at j=0, out_last at j=1055, first out_valid 2 cycles after the last input edge.
2. **Small block, π sequence.** k_size=0 with single markers at 298, 645 and 68 (separate blocks) → 1 seen at j=2, 3 and 4 respectively.
3. **Large block, single marker.** k_size=1; marker at i=743 → out_bit=1 only at j=1. 6144 outputs with out_last at j=6143.
4. **Back-to-back blocks, different sizes.** Blocks of sizes 1056 then 6144 with k_size toggled mid-block → sizes follow the first-bit sample.
   - With QPP_PINGPONG_EN: in_ready never drops, and out_valid is continuous across the boundary.
   - Without it: in_ready is low for the whole drain.
5. **Random backpressure.** out_ready driven randomly at 50% → output sequence identical to the out_ready=1 run, and out_bit is stable while stalled.
6. **Reset mid-operation.** clear_n pulsed low mid-fill and mid-drain → all outputs 0 immediately. in_ready returns 1 edge after release, and the next full block is correct.
